adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end that shares one 5-bit ripple adder.
// Optional per-requester grant counters are enabled with ADDER_ARB_STATS_EN.

module fivebitadder (
  input  logic [4:0] a_i,
  input  logic [4:0] b_i,
  output logic [4:0] s_o,
  output logic       c_o
);

  logic [5:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 5; i++) begin : g_fa
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = carry[5];

endmodule

module adder_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [4:0]       a0,
  input  logic [4:0]       b0,
  input  logic [4:0]       a1,
  input  logic [4:0]       b1,
  output logic             ack0,
  output logic             ack1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [4:0]       res_s,
  output logic             res_c
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [4:0] op_a_q, op_b_q;
  logic       id_q;
  logic [4:0] sum_q;
  logic       carry_q;
  logic       gnt0, gnt1;
  logic [4:0] add_s;
  logic       add_c;

  fivebitadder u_adder (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .s_o (add_s),
    .c_o (add_c)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      StIdle: begin
        // Gated by reset so no ack can leak out while reset is held.
        if (!reset) begin
          if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        if (gnt0 || gnt1) begin
          state_d = StCalc;
          last_d  = gnt1;
        end
      end
      StCalc:  state_d = StResp;
      StResp:  if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      op_a_q  <= '0;
      op_b_q  <= '0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (gnt0) begin
        op_a_q <= a0;
        op_b_q <= b0;
        id_q   <= 1'b0;
      end else if (gnt1) begin
        op_a_q <= a1;
        op_b_q <= b1;
        id_q   <= 1'b1;
      end
      if (state_q == StCalc) begin
        sum_q   <= add_s;
        carry_q <= add_c;
      end
    end
  end

  assign ack0      = gnt0;
  assign ack1      = gnt1;
  assign res_valid = (state_q == StResp);
  assign res_id    = id_q;
  assign res_s     = sum_q;
  assign res_c     = carry_q;

`ifdef ADDER_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
      if (gnt1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule
